rhs_cable_delay_finder: RTL

- SPI master sequencer that finds the MISO sampling delay for one RHS headstage across the cable.
- For each candidate delay it issues a fixed 5-frame ROM read sequence ("IN","TA","N\0") and checks the returned words.
- It records a pass map and picks the centre of the longest passing run.
- Sits between the acquisition controller, which pulses start and consumes best_delay, and the headstage SPI pins; runs once at link bring-up.

---
 rtl/rhs_cable_delay_finder_pkg.sv | 48 ++++
 rtl/rhs_cable_delay_finder_spi_frame_engine.sv | 83 ++++++++
 rtl/rhs_cable_delay_finder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rhs_cable_delay_finder_pkg.sv
// Shared constants, ROM read command helpers and sequencer state encoding
// for the RHS cable delay finder.
package rhs_pkg;

  localparam logic [1:0]  RHS_CMD_READ = 2'b11;

  localparam logic [7:0]  ROM_ADDR_IN  = 8'd251;
  localparam logic [7:0]  ROM_ADDR_TA  = 8'd252;
  localparam logic [7:0]  ROM_ADDR_N   = 8'd253;

  localparam logic [15:0] ROM_IN       = 16'h494E;
  localparam logic [15:0] ROM_TA       = 16'h5441;
  localparam logic [15:0] ROM_N        = 16'h4E00;

  localparam int          FRAME_BITS   = 32;
  localparam int          SCLK_DIV     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP,
    ST_EVAL,
    ST_SELECT,
    ST_DONE
  } state_t;

  function automatic logic [31:0] rom_read_cmd(input logic [7:0] addr);
    return {RHS_CMD_READ, 6'b000000, addr, 16'h0000};
  endfunction

  // Frames 0 and 1 prime the pipeline; frames 2..4 all read the last ROM word.
  function automatic logic [31:0] frame_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return rom_read_cmd(ROM_ADDR_IN);
      3'd1:    return rom_read_cmd(ROM_ADDR_TA);
      default: return rom_read_cmd(ROM_ADDR_N);
    endcase
  endfunction

  function automatic logic [15:0] frame_expect(input logic [2:0] idx);
    case (idx)
      3'd2:    return ROM_IN;
      3'd3:    return ROM_TA;
      default: return ROM_N;
    endcase
  endfunction

endpackage

// File: rtl/rhs_cable_delay_finder_spi_frame_engine.sv
// One 32-bit SPI frame (CS low, SCLK = clk/4, MSB first) followed by the CS-high
// gap, with MISO sampled a programmable number of clk cycles after each SCLK rise.
module rhs_spi_frame_engine
  import rhs_pkg::*;
#(
  parameter int DELAY_W        = 4,
  parameter int CS_HIGH_CYCLES = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        tx_word,
  input  logic [DELAY_W-1:0] delay,
  input  logic               miso,
  output logic               cs,
  output logic               sclk,
  output logic               mosi,
  output logic               frame_end,
  output logic               done,
  output logic [15:0]        rx_word
);

  localparam int LOW_CYCLES   = FRAME_BITS * SCLK_DIV;
  localparam int TOTAL_CYCLES = LOW_CYCLES + CS_HIGH_CYCLES;
  localparam int CNT_W        = $clog2(TOTAL_CYCLES + 1);
  localparam int BIT_W        = $clog2(FRAME_BITS);

  logic                  active;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [DELAY_W-1:0]    dly;
  logic [BIT_W:0]        rx_bits;
  logic [15:0]           rx_sh;
  logic                  cs_low;
  logic [CNT_W-1:0]      samp_cnt;
  logic                  sample;

  assign cs_low    = active && (cnt < CNT_W'(LOW_CYCLES));
  assign frame_end = active && (cnt == CNT_W'(LOW_CYCLES - 1));
  assign done      = active && (cnt == CNT_W'(TOTAL_CYCLES - 1));

  // SCLK rises at phase 2 of each bit; the nominal sample point is that rise.
  assign samp_cnt  = CNT_W'(rx_bits[BIT_W-1:0]) * CNT_W'(SCLK_DIV)
                   + CNT_W'(SCLK_DIV / 2) + CNT_W'(dly);
  assign sample    = active && !rx_bits[BIT_W] && (cnt == samp_cnt);

  assign cs      = !cs_low;
  assign sclk    = cs_low && cnt[1];
  assign mosi    = cs_low && tx_sh[FRAME_BITS-1];
  // Only the low half of the returned word carries data, so the shifter keeps 16 bits.
  assign rx_word = rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      tx_sh   <= '0;
      dly     <= '0;
      rx_bits <= '0;
      rx_sh   <= '0;
    end else if (start) begin
      active  <= 1'b1;
      cnt     <= '0;
      tx_sh   <= tx_word;
      dly     <= delay;
      rx_bits <= '0;
      rx_sh   <= '0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt[1:0] == 2'b11) begin
        tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
      end
      if (sample) begin
        rx_sh   <= {rx_sh[14:0], miso};
        rx_bits <= rx_bits + (BIT_W+1)'(1);
      end
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rhs_cable_delay_finder.sv
// Sweeps every MISO sampling delay with a 5-frame ROM read, records which delays
// return the expected words, and reports the centre of the longest passing run.
//
// state  | meaning
// IDLE   | waiting for start
// FRAME  | CS low, 32-bit word on the wire
// GAP    | CS high; late MISO bits still captured, result checked at the end
// EVAL   | record pass/fail for the current delay
// SELECT | scan pass_map for the longest run of passing delays
// DONE   | one-cycle result strobe
module rhs_cable_delay_finder
  import rhs_pkg::*;
#(
  parameter int DELAY_W        = 4,
  parameter int CS_HIGH_CYCLES = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [DELAY_W-1:0]         best_delay,
  output logic [(1<<DELAY_W)-1:0]    pass_map,
  output logic                       cs,
  output logic                       sclk,
  output logic                       mosi,
  input  logic                       miso,
  output logic [2:0]                 frame_idx
);

  localparam int                 NUM_DELAYS = 1 << DELAY_W;
  localparam logic [DELAY_W-1:0] DELAY_MAX  = DELAY_W'(NUM_DELAYS - 1);
  localparam logic [DELAY_W:0]   LEN_ONE    = (DELAY_W+1)'(1);

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] delay;
  logic               frame_ok;
  logic [DELAY_W-1:0] scan_idx;
  logic [DELAY_W:0]   run_len, best_len;
  logic [DELAY_W-1:0] run_start, best_start;

  logic               eng_start, eng_frame_end, eng_done;
  logic [31:0]        eng_tx;
  logic [DELAY_W-1:0] eng_delay;
  logic [15:0]        rx_word;

  logic               last_frame, last_delay, last_scan, sel_bit;
  logic [DELAY_W:0]   run_len_nxt, best_len_nxt;
  logic [DELAY_W-1:0] run_start_nxt, best_start_nxt, centre;

  assign last_frame = (frame_idx == 3'd4);
  assign last_delay = (delay == DELAY_MAX);
  assign last_scan  = (scan_idx == DELAY_MAX);

  rhs_spi_frame_engine #(
    .DELAY_W        (DELAY_W),
    .CS_HIGH_CYCLES (CS_HIGH_CYCLES)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .tx_word   (eng_tx),
    .delay     (eng_delay),
    .miso      (miso),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .frame_end (eng_frame_end),
    .done      (eng_done),
    .rx_word   (rx_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    eng_tx    = frame_cmd(3'd0);
    eng_delay = '0;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FRAME;
          eng_start = 1'b1;
        end
      end
      ST_FRAME: begin
        if (eng_frame_end) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        eng_tx    = frame_cmd(frame_idx + 3'd1);
        eng_delay = delay;
        if (eng_done) begin
          if (last_frame) begin
            state_nxt = ST_EVAL;
          end else begin
            state_nxt = ST_FRAME;
            eng_start = 1'b1;
          end
        end
      end
      ST_EVAL: begin
        eng_delay = delay + DELAY_W'(1);
        if (last_delay) begin
          state_nxt = ST_SELECT;
        end else begin
          state_nxt = ST_FRAME;
          eng_start = 1'b1;
        end
      end
      ST_SELECT: begin
        if (last_scan) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strict '>' keeps the earliest run on a tie in length.
  always_comb begin
    sel_bit        = pass_map[scan_idx];
    run_len_nxt    = sel_bit ? run_len + LEN_ONE : '0;
    run_start_nxt  = (sel_bit && (run_len == '0)) ? scan_idx : run_start;
    best_len_nxt   = best_len;
    best_start_nxt = best_start;
    if (sel_bit && (run_len_nxt > best_len)) begin
      best_len_nxt   = run_len_nxt;
      best_start_nxt = run_start_nxt;
    end
    centre = '0;
    if (best_len_nxt != '0) begin
      centre = best_start_nxt + DELAY_W'((best_len_nxt - LEN_ONE) >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_idx  <= '0;
      delay      <= '0;
      frame_ok   <= 1'b0;
      pass_map   <= '0;
      scan_idx   <= '0;
      run_len    <= '0;
      run_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
      best_delay <= '0;
      found      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            frame_idx  <= '0;
            delay      <= '0;
            frame_ok   <= 1'b1;
            pass_map   <= '0;
            best_delay <= '0;
            found      <= 1'b0;
          end
        end
        ST_GAP: begin
          if (eng_done) begin
            if (frame_idx >= 3'd2) begin
              frame_ok <= frame_ok && (rx_word == frame_expect(frame_idx));
            end
            if (!last_frame) frame_idx <= frame_idx + 3'd1;
          end
        end
        ST_EVAL: begin
          pass_map[delay] <= frame_ok;
          frame_idx       <= '0;
          frame_ok        <= 1'b1;
          if (!last_delay) begin
            delay <= delay + DELAY_W'(1);
          end else begin
            scan_idx   <= '0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
          end
        end
        ST_SELECT: begin
          run_len    <= run_len_nxt;
          run_start  <= run_start_nxt;
          best_len   <= best_len_nxt;
          best_start <= best_start_nxt;
          scan_idx   <= scan_idx + DELAY_W'(1);
          if (last_scan) begin
            best_delay <= centre;
            found      <= (pass_map != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
